// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner:
// blank pattern, hex segment table and per-digit slot length derivation.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic int calc_tick_div(input int clk_hz, input int refresh_hz,
                                         input int num_digits);
        return clk_hz / (refresh_hz * num_digits);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous update
// buffer, leading-zero suppression, PWM brightness and a dead cycle per slot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 500,
    parameter int BR_W       = 4,
    parameter int TICK_DIV   = calc_tick_div(CLK_HZ, REFRESH_HZ, NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic                    lz_en,
    input  logic [BR_W-1:0]         brightness,
    output logic                    frame_start,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int SLOT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BR_W-1:0]         pwm_q, pwm_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] hold_data_q, hold_data_d;
    logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d;
    logic [NUM_DIGITS-1:0]   hold_blank_q, hold_blank_d;
    logic [4*NUM_DIGITS-1:0] data_s_q, data_s_d;
    logic [NUM_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [NUM_DIGITS-1:0]   blank_s_q, blank_s_d;
    logic                    frame_start_q, frame_start_d;
    logic [6:0]              a_to_g_q, a_to_g_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic                    boundary;
    logic                    accept;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   visible;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_visible;
    logic                    cur_lit;
    logic [6:0]              dec_seg;

    assign tick      = (slot_q == SLOT_LAST);
    assign boundary  = tick && (idx_q == IDX_LAST);
    assign upd_ready = !pending_q;
    assign accept    = upd_valid && !pending_q;
    assign commit    = boundary && pending_q;

    always_comb begin
        slot_d = tick ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_d         = pwm_q + 1'b1;
        frame_start_d = boundary;
    end

    // Hold takes new data any time it is free; shadow only changes at a
    // frame wrap so a single frame never mixes old and new digits.
    always_comb begin
        pending_d    = pending_q;
        hold_data_d  = hold_data_q;
        hold_dp_d    = hold_dp_q;
        hold_blank_d = hold_blank_q;
        data_s_d     = data_s_q;
        dp_s_d       = dp_s_q;
        blank_s_d    = blank_s_q;
        if (commit) begin
            data_s_d  = hold_data_q;
            dp_s_d    = hold_dp_q;
            blank_s_d = hold_blank_q;
            pending_d = 1'b0;
        end else if (accept) begin
            hold_data_d  = data;
            hold_dp_d    = dp_in;
            hold_blank_d = blank_in;
            pending_d    = 1'b1;
        end
    end

    // Walk from the most significant digit down so zero_run means
    // "this nibble and every nibble above it is zero".
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        visible  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (data_s_q[4*i +: 4] == 4'h0);
            visible[i] = !blank_s_q[i] && !(lz_en && (i != 0) && zero_run);
        end
    end

    always_comb begin
        cur_nibble  = 4'h0;
        cur_dp      = 1'b0;
        cur_visible = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble  = data_s_q[4*i +: 4];
                cur_dp      = dp_s_q[i];
                cur_visible = visible[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Slot cycle 0 keeps every anode off so the previous digit's segments
    // never bleed into the next one.
    always_comb begin
        cur_lit  = cur_visible && (pwm_q <= brightness) && (slot_q != '0);
        a_to_g_d = cur_visible ? dec_seg : SEG_BLANK;
        dp_d     = cur_visible ? !cur_dp : 1'b1;
        an_d     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                an_d[i] = !cur_lit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            pending_q     <= 1'b0;
            hold_data_q   <= '0;
            hold_dp_q     <= '0;
            hold_blank_q  <= '0;
            data_s_q      <= '0;
            dp_s_q        <= '0;
            blank_s_q     <= '1;
            frame_start_q <= 1'b0;
            a_to_g_q      <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            pending_q     <= pending_d;
            hold_data_q   <= hold_data_d;
            hold_dp_q     <= hold_dp_d;
            hold_blank_q  <= hold_blank_d;
            data_s_q      <= data_s_d;
            dp_s_q        <= dp_s_d;
            blank_s_q     <= blank_s_d;
            frame_start_q <= frame_start_d;
            a_to_g_q      <= a_to_g_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign frame_start = frame_start_q;
    assign a_to_g      = a_to_g_q;
    assign dp          = dp_q;
    assign an          = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed and randomized bench for seg7_scan_ctrl; every cycle is compared
// against a reference model that derives timing from the cycle count alone.
module tb_seg7_scan_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int CLK_HZ     = 800;
    localparam int REFRESH_HZ = 10;
    localparam int BR_W       = 4;
    localparam int TICK       = 20;
    localparam int FRAME      = TICK * NUM_DIGITS;
    localparam int PWM_PERIOD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        upd_valid = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  brightness = '0;
    logic        upd_ready;
    logic        frame_start;
    logic [6:0]  a_to_g;
    logic        dp;
    logic [3:0]  an;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: k = clock edges since reset release.
    int          k;
    logic        mPending;
    logic [15:0] mHoldData, mShowData;
    logic [3:0]  mHoldDp, mShowDp;
    logic [3:0]  mHoldBlank, mShowBlank;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
    logic        expFs;

    logic [6:0] segTable [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .BR_W       (BR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .frame_start (frame_start),
        .a_to_g      (a_to_g),
        .dp          (dp),
        .an          (an)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic bit digitVisible(input int i, input logic [15:0] d,
                                        input logic [3:0] bl, input logic lz);
        logic [15:0] dv;
        bit allZero;
        dv = d;
        if (bl[i]) return 1'b0;
        if (lz && i != 0) begin
            allZero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++)
                if (dv[4*j +: 4] != 4'h0) allZero = 1'b0;
            if (allZero) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] randData();
        logic [15:0] d;
        d = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'($urandom);
        return d;
    endfunction

    task automatic modelInit();
        k          = 0;
        mPending   = 1'b0;
        mHoldData  = '0;
        mHoldDp    = '0;
        mHoldBlank = '0;
        mShowData  = '0;
        mShowDp    = '0;
        mShowBlank = '1;
        expAn      = 4'hF;
        expSeg     = 7'h7F;
        expDp      = 1'b1;
        expFs      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] bl, input logic valid);
        data      = d;
        dp_in     = dpv;
        blank_in  = bl;
        upd_valid = valid;
    endtask

    task automatic checkOutput();
        checkVal("an", 32'(an), 32'(expAn));
        checkVal("a_to_g", 32'(a_to_g), 32'(expSeg));
        checkVal("dp", 32'(dp), 32'(expDp));
        checkVal("frame_start", 32'(frame_start), 32'(expFs));
        checkVal("upd_ready", 32'(upd_ready), 32'(!mPending));
    endtask

    // Compare, predict the outputs of the coming edge, advance the model,
    // then move to the next falling edge.
    task automatic stepCycle();
        int slot;
        int idx;
        int pwm;
        bit vis;
        bit boundary;
        checkOutput();
        slot     = k % TICK;
        idx      = (k / TICK) % NUM_DIGITS;
        pwm      = k % PWM_PERIOD;
        boundary = (k % FRAME) == FRAME - 1;
        vis      = digitVisible(idx, mShowData, mShowBlank, lz_en);
        expSeg   = vis ? segTable[mShowData[4*idx +: 4]] : 7'h7F;
        expDp    = vis ? !mShowDp[idx] : 1'b1;
        expAn    = 4'hF;
        if (vis && pwm <= int'(brightness) && slot != 0) expAn[idx] = 1'b0;
        expFs    = boundary;
        if (boundary && mPending) begin
            mShowData  = mHoldData;
            mShowDp    = mHoldDp;
            mShowBlank = mHoldBlank;
            mPending   = 1'b0;
        end else if (upd_valid && !mPending) begin
            mHoldData  = data;
            mHoldDp    = dp_in;
            mHoldBlank = blank_in;
            mPending   = 1'b1;
        end
        k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runTo(input int target);
        while (k < target) stepCycle();
    endtask

    initial begin
        int litCount;
        int litExpected;

        $display("[TB] start");
        modelInit();
        repeat (3) @(negedge clk);
        checkVal("reset_an", 32'(an), 32'hF);
        checkVal("reset_seg", 32'(a_to_g), 32'h7F);
        checkVal("reset_ready", 32'(upd_ready), 32'h1);
        reset = 1'b1;

        // First update: nothing lit until the boundary commit.
        brightness = 4'd15;
        applyStimulus(16'h12A0, 4'b0010, 4'b0000, 1'b1);
        stepCycle();
        upd_valid = 1'b0;
        runTo(50);
        checkVal("dark_before_commit", 32'(an), 32'hF);
        runTo(79);
        checkVal("ready_while_pending", 32'(upd_ready), 32'h0);
        runTo(80);
        checkVal("ready_after_commit", 32'(upd_ready), 32'h1);
        checkVal("frame_start_wrap", 32'(frame_start), 32'h1);
        runTo(81);
        checkVal("dead_cycle_an", 32'(an), 32'hF);
        runTo(82);
        checkVal("d0_an", 32'(an), 32'b1110);
        checkVal("d0_seg", 32'(a_to_g), 32'b1000000);
        checkVal("d0_dp", 32'(dp), 32'h1);
        runTo(102);
        checkVal("d1_an", 32'(an), 32'b1101);
        checkVal("d1_seg", 32'(a_to_g), 32'b0001000);
        checkVal("d1_dp", 32'(dp), 32'h0);
        runTo(142);
        checkVal("d3_seg", 32'(a_to_g), 32'b1111001);

        // Leading-zero suppression on 0070.
        runTo(150);
        lz_en = 1'b1;
        applyStimulus(16'h0070, 4'b0000, 4'b0000, 1'b1);
        stepCycle();
        upd_valid = 1'b0;
        runTo(245);
        checkVal("lz_d0_seg", 32'(a_to_g), 32'b1000000);
        checkVal("lz_d0_an", 32'(an), 32'b1110);
        runTo(265);
        checkVal("lz_d1_seg", 32'(a_to_g), 32'b1111000);
        runTo(285);
        checkVal("lz_d2_an", 32'(an), 32'hF);
        checkVal("lz_d2_seg", 32'(a_to_g), 32'h7F);
        runTo(305);
        checkVal("lz_d3_an", 32'(an), 32'hF);
        runTo(320);
        lz_en = 1'b0;
        runTo(365);
        checkVal("nolz_d2_seg", 32'(a_to_g), 32'b1000000);
        checkVal("nolz_d2_an", 32'(an), 32'b1011);
        runTo(385);
        checkVal("nolz_d3_an", 32'(an), 32'b0111);

        // Back-to-back updates: second waits for the commit of the first.
        runTo(400);
        applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b1);
        stepCycle();
        applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b1);
        runTo(450);
        checkVal("b2b_ready_low", 32'(upd_ready), 32'h0);
        runTo(480);
        checkVal("b2b_ready_high", 32'(upd_ready), 32'h1);
        stepCycle();
        checkVal("b2b_second_taken", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        runTo(482);
        checkVal("b2b_first_d0", 32'(a_to_g), 32'b1111001);
        runTo(545);
        checkVal("b2b_first_d3", 32'(a_to_g), 32'b1111001);
        runTo(562);
        checkVal("b2b_second_d0", 32'(a_to_g), 32'b0100100);

        // Brightness 3: count lit output cycles over one frame.
        runTo(600);
        brightness = 4'd3;
        runTo(640);
        litExpected = 0;
        for (int s = 640; s < 720; s++)
            if ((s % PWM_PERIOD) <= 3 && (s % TICK) != 0) litExpected++;
        litCount = 0;
        while (k < 720) begin
            stepCycle();
            if (an !== 4'hF) litCount++;
        end
        checkVal("pwm_lit_count", 32'(litCount), 32'(litExpected));

        // Capture on the boundary cycle itself commits one frame later.
        runTo(799);
        applyStimulus(16'h3333, 4'b0000, 4'b0000, 1'b1);
        stepCycle();
        upd_valid = 1'b0;
        checkVal("bnd_ready_low", 32'(upd_ready), 32'h0);
        checkVal("bnd_frame_start", 32'(frame_start), 32'h1);
        runTo(802);
        checkVal("bnd_old_still_shown", 32'(a_to_g), 32'b0100100);
        runTo(880);
        checkVal("bnd_frame_start2", 32'(frame_start), 32'h1);
        runTo(882);
        checkVal("bnd_new_shown", 32'(a_to_g), 32'b0110000);

        // Reset in the middle of a lit digit 2 slot.
        brightness = 4'd15;
        runTo(925);
        checkVal("pre_reset_d2_lit", 32'(an), 32'b1011);
        #3 reset = 1'b0;
        #1;
        checkVal("mid_reset_an", 32'(an), 32'hF);
        checkVal("mid_reset_seg", 32'(a_to_g), 32'h7F);
        checkVal("mid_reset_dp", 32'(dp), 32'h1);
        checkVal("mid_reset_ready", 32'(upd_ready), 32'h1);
        checkVal("mid_reset_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkVal("held_reset_an", 32'(an), 32'hF);
        reset = 1'b1;
        modelInit();

        // Randomized traffic against the model.
        for (int n = 0; n < 1200; n++) begin
            if ($urandom_range(0, 7) == 0)
                applyStimulus(randData(), 4'($urandom),
                              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'b1);
            else
                upd_valid = 1'b0;
            if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
            stepCycle();
        end
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
